if_fetch_unit: RTL and testbench
================================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high, ports named clk and rst.
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- freeze  in  1  downstream stall; delivered instruction must be held
- branch_taken  in  1  redirect request from EX
- branch_addr  in  32  redirect target byte address
- imem_req  out  1  instruction memory request
- imem_addr  out  32  fetch address, word aligned
- imem_rdata  in  32  instruction word, valid when imem_ready=1
- imem_ready  in  1  memory accept/return strobe for the current request
- pc  out  32  fetch address + 4 of the delivered instruction
- instruction  out  32  delivered instruction word
- if_valid  out  1  pc/instruction carry a new instruction this cycle

Function
REQ-003 SHALL use states FETCH (request outstanding) and HOLD (word captured while frozen), plus a squash flag and a 32-bit redirect target register.
REQ-004 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal fetch_pc, held stable until imem_ready=1.
REQ-005 FETCH with imem_ready=1, no squash, no branch_taken, freeze=0: pc<=fetch_pc+4, instruction<=imem_rdata, if_valid<=1, fetch_pc<=fetch_pc+4, remain in FETCH (one instruction/cycle with zero-wait memory).
REQ-006 FETCH with imem_ready=1, freeze=1, no redirect: capture imem_rdata and fetch_pc into hold buffer, go to HOLD; imem_req=0 in HOLD.
REQ-007 HOLD with freeze=0: deliver buffered word (if_valid<=1), fetch_pc<=buffered pc+4, go to FETCH.
REQ-008 While freeze=1, pc and instruction SHALL hold their values and if_valid SHALL be 0.
REQ-009 Cycles with no delivery SHALL drive if_valid=0; pc/instruction hold their values.
REQ-010 branch_taken in FETCH without imem_ready: set squash, latch branch_addr; the request stays outstanding at the old address until imem_ready.
REQ-011 imem_ready with squash set, or coincident with branch_taken: discard data, fetch_pc<=target (coincident branch_addr wins over latched target), clear squash, stay in FETCH.
REQ-012 branch_taken in HOLD: drop buffered word, fetch_pc<=branch_addr, go to FETCH.
REQ-013 branch_taken SHALL take priority over freeze; a second branch_taken while squash set SHALL overwrite the latched target.
REQ-014 Address arithmetic SHALL be modulo 2^32 (0xFFFFFFFC+4 wraps to 0).
REQ-015 branch_addr[1:0] SHALL be ignored (forced to 00).

Reset
REQ-016 rst=1 at a clock edge SHALL set fetch_pc=0, pc=0, instruction=0, if_valid=0, squash=0, target=0, state=FETCH; an outstanding request is abandoned.
REQ-017 The first cycle after reset deasserts SHALL drive imem_req=1, imem_addr=0.

Configuration
REQ-018 Macro IF_PERF_CNT_EN defined: add outputs fetch_cnt[31:0] (delivered instructions) and squash_cnt[31:0] (discarded words), both reset to 0 and wrapping modulo 2^32.
REQ-019 Macro IF_PERF_CNT_EN undefined: counters and ports absent; all other behaviour identical.

Structure
REQ-020 Shared package arm_pkg SHALL hold WORD_W=32, PC_STEP=4, RESET_PC=0 and the fetch state enum.
REQ-021 The one-entry hold buffer SHALL be sub-module if_hold_buf (load, clear, data+pc out).

Verification
REQ-022 Reset, imem_ready tied 1, freeze=0: if_valid=1 every cycle from cycle 2, pc=4,8,12..., imem_addr=0,4,8....
REQ-023 imem_ready delayed 3 cycles at addr 0x10: imem_addr stays 0x10 throughout, one delivery with pc=0x14.
REQ-024 freeze=1 for 4 cycles on return of addr 0x20: state HOLD, imem_req=0, if_valid=0; freeze drops -> instruction delivered with pc=0x24, next imem_addr=0x24.
REQ-025 branch_taken to 0x100 while request to 0x40 pending: 0x40 data discarded (if_valid=0), next imem_addr=0x100, squash_cnt increments by 1.
REQ-026 branch_taken to 0x200 together with freeze=1 in HOLD: buffer dropped, imem_addr=0x200 next cycle.
REQ-027 rst asserted mid-wait at addr 0x80: next cycle imem_addr=0, if_valid=0, counters=0.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared fetch-stage definitions: word width, PC step/reset value, fetch FSM states.
package arm_pkg;

   localparam int                WORD_W   = 32;
   localparam logic [WORD_W-1:0] PC_STEP  = 32'd4;
   localparam logic [WORD_W-1:0] RESET_PC = 32'd0;

   typedef enum logic [0:0] {
      ST_FETCH = 1'b0,
      ST_HOLD  = 1'b1
   } fetch_state_e;

   function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry buffer keeping a returned instruction word and its fetch address while the pipe is frozen.
module if_hold_buf
   import arm_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic [WORD_W-1:0] data_in,
   input  logic [WORD_W-1:0] pc_in,
   output logic [WORD_W-1:0] data,
   output logic [WORD_W-1:0] pc
);

   // buffer storage; clear wins over load
   always_ff @(posedge clk) begin
      if (rst) begin
         data <= 32'd0;
         pc   <= 32'd0;
      end else if (clear) begin
         data <= 32'd0;
         pc   <= 32'd0;
      end else if (load) begin
         data <= data_in;
         pc   <= pc_in;
      end else begin
         data <= data;
         pc   <= pc;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: one request in flight, freeze hold buffer, branch squash/redirect.
// Optional IF_PERF_CNT_EN adds fetch_cnt/squash_cnt performance counters.
module if_fetch_unit
   import arm_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              branch_taken,
   input  logic [WORD_W-1:0] branch_addr,
   output logic              imem_req,
   output logic [WORD_W-1:0] imem_addr,
   input  logic [WORD_W-1:0] imem_rdata,
   input  logic              imem_ready,
   output logic [WORD_W-1:0] pc,
   output logic [WORD_W-1:0] instruction,
   output logic              if_valid
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]       fetch_cnt,
   output logic [31:0]       squash_cnt
`endif
);

   fetch_state_e      state_r, state_s;
   logic [WORD_W-1:0] fetch_pc_r, fetch_pc_s;
   logic              squash_r, squash_s;
   logic [WORD_W-1:0] target_r, target_s;
   logic [WORD_W-1:0] pc_s, instr_s;
   logic              deliver_s, discard_s;
   logic              buf_load_s, buf_clear_s;
   logic [WORD_W-1:0] buf_data_s, buf_pc_s;
   logic [WORD_W-1:0] br_target_s;

   assign br_target_s = word_align(branch_addr);
   assign imem_req    = (state_r == ST_FETCH);
   assign imem_addr   = fetch_pc_r;

   if_hold_buf u_hold_buf (
      .clk     (clk),
      .rst     (rst),
      .load    (buf_load_s),
      .clear   (buf_clear_s),
      .data_in (imem_rdata),
      .pc_in   (fetch_pc_r),
      .data    (buf_data_s),
      .pc      (buf_pc_s)
   );

   // next-state, redirect and delivery decisions
   always_comb begin
      state_s     = state_r;
      fetch_pc_s  = fetch_pc_r;
      squash_s    = squash_r;
      target_s    = target_r;
      pc_s        = pc;
      instr_s     = instruction;
      deliver_s   = 1'b0;
      discard_s   = 1'b0;
      buf_load_s  = 1'b0;
      buf_clear_s = 1'b0;
      case (state_r)
         ST_FETCH: begin
            if (imem_ready) begin
               if (branch_taken || squash_r) begin
                  // a coincident branch overrides any previously latched target
                  discard_s = 1'b1;
                  squash_s  = 1'b0;
                  if (branch_taken) begin
                     fetch_pc_s = br_target_s;
                  end else begin
                     fetch_pc_s = target_r;
                  end
               end else if (freeze) begin
                  buf_load_s = 1'b1;
                  state_s    = ST_HOLD;
               end else begin
                  deliver_s  = 1'b1;
                  pc_s       = fetch_pc_r + PC_STEP;
                  instr_s    = imem_rdata;
                  fetch_pc_s = fetch_pc_r + PC_STEP;
               end
            end else if (branch_taken) begin
               squash_s = 1'b1;
               target_s = br_target_s;
            end else begin
               state_s = ST_FETCH;
            end
         end
         ST_HOLD: begin
            if (branch_taken) begin
               discard_s   = 1'b1;
               buf_clear_s = 1'b1;
               fetch_pc_s  = br_target_s;
               state_s     = ST_FETCH;
            end else if (!freeze) begin
               deliver_s   = 1'b1;
               buf_clear_s = 1'b1;
               pc_s        = buf_pc_s + PC_STEP;
               instr_s     = buf_data_s;
               fetch_pc_s  = buf_pc_s + PC_STEP;
               state_s     = ST_FETCH;
            end else begin
               state_s = ST_HOLD;
            end
         end
         default: begin
            state_s = ST_FETCH;
         end
      endcase
   end

   // state, fetch address and delivered-instruction registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_FETCH;
         fetch_pc_r  <= RESET_PC;
         squash_r    <= 1'b0;
         target_r    <= 32'd0;
         pc          <= 32'd0;
         instruction <= 32'd0;
         if_valid    <= 1'b0;
      end else begin
         state_r     <= state_s;
         fetch_pc_r  <= fetch_pc_s;
         squash_r    <= squash_s;
         target_r    <= target_s;
         pc          <= pc_s;
         instruction <= instr_s;
         if_valid    <= deliver_s;
      end
   end

`ifdef IF_PERF_CNT_EN
   // delivered / discarded word counters, wrapping
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt  <= 32'd0;
         squash_cnt <= 32'd0;
      end else begin
         fetch_cnt  <= fetch_cnt + {31'd0, deliver_s};
         squash_cnt <= squash_cnt + {31'd0, discard_s};
      end
   end
`else
   logic unused_discard_s;
   assign unused_discard_s = discard_s;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios then randomized traffic vs a reference model.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst, freeze, branch_taken, imem_ready;
   logic [31:0] branch_addr;
   logic        imem_req, if_valid;
   logic [31:0] imem_addr, imem_rdata, pc, instruction;
`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt, squash_cnt;
`endif

   int checks = 0;
   int errors = 0;

   // reference model: next address to fetch, optional held word, optional pending redirect
   logic [31:0] m_addr, m_target;
   bit          m_redir;
   logic [31:0] m_held[$];
   logic [31:0] exp_pc, exp_instr;
   logic        exp_valid;
   logic [31:0] m_fetched, m_squashed;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h0F1E_2D3C;
   endfunction

   assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

   if_fetch_unit dut (
      .clk          (clk),
      .rst          (rst),
      .freeze       (freeze),
      .branch_taken (branch_taken),
      .branch_addr  (branch_addr),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .imem_ready   (imem_ready),
      .pc           (pc),
      .instruction  (instruction),
      .if_valid     (if_valid)
`ifdef IF_PERF_CNT_EN
      ,
      .fetch_cnt    (fetch_cnt),
      .squash_cnt   (squash_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_addr = 32'd0; m_target = 32'd0; m_redir = 1'b0; m_held.delete();
      exp_pc = 32'd0; exp_instr = 32'd0; exp_valid = 1'b0;
      m_fetched = 32'd0; m_squashed = 32'd0;
   endtask

   task automatic model_deliver(input logic [31:0] a);
      exp_pc = a + 32'd4; exp_instr = mem_word(a); exp_valid = 1'b1;
      m_addr = a + 32'd4; m_fetched++;
   endtask

   task automatic model_step();
      logic [31:0] tgt;
      logic [31:0] a;
      tgt = branch_addr & 32'hFFFF_FFFC;
      exp_valid = 1'b0;
      if (m_held.size() > 0) begin
         if (branch_taken) begin
            m_held.delete(); m_addr = tgt; m_squashed++;
         end else if (!freeze) begin
            a = m_held.pop_front();
            model_deliver(a);
         end
      end else if (imem_ready) begin
         if (branch_taken) begin
            m_addr = tgt; m_redir = 1'b0; m_squashed++;
         end else if (m_redir) begin
            m_addr = m_target; m_redir = 1'b0; m_squashed++;
         end else if (freeze) begin
            m_held.push_back(m_addr);
         end else begin
            model_deliver(m_addr);
         end
      end else if (branch_taken) begin
         m_redir = 1'b1; m_target = tgt;
      end
   endtask

   // check request outputs, advance model and DUT one clock, check delivered outputs
   task automatic cycle(input string tag);
      if (!rst) begin
         chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, (m_held.size() == 0)});
         if (m_held.size() == 0) chk({tag, ".addr"}, imem_addr, m_addr);
      end
      if (rst) model_reset();
      else model_step();
      @(posedge clk);
      #1;
      chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, exp_valid});
      chk({tag, ".pc"}, pc, exp_pc);
      chk({tag, ".instr"}, instruction, exp_instr);
`ifdef IF_PERF_CNT_EN
      chk({tag, ".fcnt"}, fetch_cnt, m_fetched);
      chk({tag, ".scnt"}, squash_cnt, m_squashed);
`endif
   endtask

   task automatic set_in(input logic r, input logic f, input logic b, input logic [31:0] ba);
      imem_ready = r; freeze = f; branch_taken = b; branch_addr = ba;
   endtask

`ifdef IF_PERF_CNT_EN
   logic [31:0] sq0;
`endif

   initial begin
      rst = 1'b1;
      set_in(1'b0, 1'b0, 1'b0, 32'd0);
      model_reset();
      cycle("reset0");
      cycle("reset1");
      rst = 1'b0;
      chk("post_reset.req", {31'd0, imem_req}, 32'd1);
      chk("post_reset.addr", imem_addr, 32'd0);

      // zero-wait streaming
      set_in(1'b1, 1'b0, 1'b0, 32'd0);
      for (int i = 0; i < 8; i++) begin
         chk("stream.addr_k", imem_addr, 32'(4 * i));
         cycle("stream");
         chk("stream.valid_k", {31'd0, if_valid}, 32'd1);
         chk("stream.pc_k", pc, 32'(4 * (i + 1)));
      end

      // three wait states at 0x10
      set_in(1'b1, 1'b0, 1'b1, 32'h10);
      cycle("redir10");
      set_in(1'b0, 1'b0, 1'b0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         chk("wait.addr_k", imem_addr, 32'h10);
         cycle("wait");
      end
      set_in(1'b1, 1'b0, 1'b0, 32'd0);
      cycle("wait_done");
      chk("wait.pc_k", pc, 32'h14);

      // freeze over the return of 0x20
      set_in(1'b1, 1'b0, 1'b1, 32'h20);
      cycle("redir20");
      set_in(1'b1, 1'b1, 1'b0, 32'd0);
      for (int i = 0; i < 4; i++) begin
         cycle("freeze");
         chk("freeze.req_k", {31'd0, imem_req}, 32'd0);
         chk("freeze.valid_k", {31'd0, if_valid}, 32'd0);
      end
      set_in(1'b0, 1'b0, 1'b0, 32'd0);
      cycle("unfreeze");
      chk("unfreeze.pc_k", pc, 32'h24);
      chk("unfreeze.instr_k", instruction, mem_word(32'h20));
      chk("unfreeze.addr_k", imem_addr, 32'h24);

      // branch while 0x40 pending; second branch overrides, low bits dropped
      set_in(1'b1, 1'b0, 1'b1, 32'h40);
      cycle("redir40");
`ifdef IF_PERF_CNT_EN
      sq0 = squash_cnt;
`endif
      set_in(1'b0, 1'b0, 1'b1, 32'h300);
      cycle("squash_a");
      set_in(1'b0, 1'b1, 1'b1, 32'h103);
      cycle("squash_b");
      chk("squash.addr_k", imem_addr, 32'h40);
      set_in(1'b1, 1'b0, 1'b0, 32'd0);
      cycle("squash_ret");
      chk("squash.valid_k", {31'd0, if_valid}, 32'd0);
      chk("squash.addr100", imem_addr, 32'h100);
`ifdef IF_PERF_CNT_EN
      chk("squash.cnt_k", squash_cnt, sq0 + 32'd1);
`endif

      // branch together with freeze while holding
      set_in(1'b1, 1'b0, 1'b1, 32'h50);
      cycle("redir50");
      set_in(1'b1, 1'b1, 1'b0, 32'd0);
      cycle("hold50");
      set_in(1'b0, 1'b1, 1'b1, 32'h200);
      cycle("hold_br");
      chk("hold_br.req_k", {31'd0, imem_req}, 32'd1);
      chk("hold_br.addr_k", imem_addr, 32'h200);

      // address wrap
      set_in(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
      cycle("redir_top");
      set_in(1'b1, 1'b0, 1'b0, 32'd0);
      cycle("wrap");
      chk("wrap.pc_k", pc, 32'd0);
      chk("wrap.addr_k", imem_addr, 32'd0);

      // reset while waiting at 0x80
      set_in(1'b1, 1'b0, 1'b1, 32'h80);
      cycle("redir80");
      set_in(1'b0, 1'b0, 1'b0, 32'd0);
      cycle("wait80");
      rst = 1'b1;
      cycle("mid_reset");
      rst = 1'b0;
      chk("mid_reset.addr_k", imem_addr, 32'd0);
      chk("mid_reset.valid_k", {31'd0, if_valid}, 32'd0);
      chk("mid_reset.pc_k", pc, 32'd0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(99) == 0);
         set_in($urandom_range(9) < 7, $urandom_range(9) < 3, $urandom_range(9) == 0, $urandom);
         cycle("rand");
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
